// File: rtl/flappy_game_engine.sv
// Flappy game engine: bird physics, pipe scroll/respawn, scoring and
// collision, stepped by an internal frame tick; drives the pixel painter.
module flappy_game_engine #(
  parameter int          TICK_DIV   = 1666667,
  parameter int          BIRD_X     = 300,
  parameter int          BIRD_Y0    = 275,
  parameter int          GRAV       = 1,
  parameter int          FLAP_VEL   = -8,
  parameter int          VMAX       = 8,
  parameter int          PIPE_SPEED = 2,
  parameter int          GAP        = 100,
  parameter int          DEAD_TICKS = 60,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          COLLIDE_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        button,
  output logic [9:0]  BirdX,
  output logic [9:0]  BirdY,
  output logic [9:0]  PipeX1,
  output logic [9:0]  PipeY1,
  output logic [9:0]  PipeX2,
  output logic [9:0]  PipeY2,
  output logic [15:0] score,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10,
    BAD  = 2'b11
  } state_t;

  localparam logic [9:0] BX    = 10'(BIRD_X);
  localparam logic [9:0] BY0   = 10'(BIRD_Y0);
  localparam logic [9:0] BYF   = 10'(BIRD_Y0 + FLAP_VEL);
  localparam logic [9:0] PSPD  = 10'(PIPE_SPEED);
  localparam logic [9:0] SPAWN = 10'd834;
  localparam logic [9:0] X_LO  = 10'd94;
  localparam logic [9:0] X_P2  = 10'd464;
  localparam logic [9:0] Y_RST = 10'd200;
  localparam logic signed [5:0] FV    = 6'(FLAP_VEL);
  localparam logic signed [6:0] VM7   = 7'(VMAX);
  localparam logic signed [6:0] GRAV7 = 7'(GRAV);

  state_t st, st_n;
  logic [31:0] cnt;
  logic        tick, upd;
  logic [15:0] lfsr;
  logic [2:0]  bsync;
  logic        rise, flap_req, flap;
  logic signed [5:0] vel, vel_n, vp;
  logic signed [6:0] vg;
  logic signed [10:0] ys;
  logic        floor_hit, crash;
  logic [9:0]  yc, gap_y, x1m, x2m;
  logic [9:0]  p1x, p1y, p2x, p2y;
  logic [9:0]  by_n, px1_n, py1_n, px2_n, py2_n;
  logic [16:0] ssum;
  logic [15:0] score_n, dead_cnt, dead_n;

  assign tick      = (cnt == 32'(TICK_DIV - 1));
  assign upd       = tick || (st == BAD);
  assign rise      = bsync[1] & ~bsync[2];
  assign flap      = flap_req | rise;
  assign gap_y     = 10'd75 + {2'b00, lfsr[7:0]};
  assign BirdX     = BX;
  assign state     = st;
  assign game_over = (st == DEAD);

  function automatic logic hit(input logic [9:0] px,
                               input logic [9:0] py,
                               input logic [9:0] y);
    int dx;
    dx = BIRD_X - int'(px);
    if (dx < 0) dx = -dx;
    return (px != 10'd0) && (dx <= 60) &&
           ((int'(y) - 10 <= int'(py)) ||
            (int'(y) + 10 >= int'(py) + GAP));
  endfunction

  // frame tick divider
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else          cnt <= tick ? '0 : cnt + 32'd1;

  // free-running gap generator, steps every clock
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // button synchronizer and sticky flap request, consumed by each tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bsync    <= '0;
      flap_req <= 1'b0;
    end else begin
      bsync <= {bsync[1:0], button};
      if (tick)      flap_req <= 1'b0;
      else if (rise) flap_req <= 1'b1;
    end

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  st <= IDLE;
    else if (upd)  st <= st_n;

  // next state and next game values
  always_comb begin
    st_n    = st;
    vel_n   = vel;
    by_n    = BirdY;
    px1_n   = PipeX1;
    py1_n   = PipeY1;
    px2_n   = PipeX2;
    py2_n   = PipeY2;
    score_n = score;
    dead_n  = dead_cnt;
    vg = {vel[5], vel} + GRAV7;
    vp = flap ? FV : ((vg > VM7) ? VM7[5:0] : vg[5:0]);
    ys = $signed({1'b0, BirdY}) + $signed({{5{vp[5]}}, vp});
    floor_hit = (ys >= 11'sd505);
    if (ys < 11'sd45)                      yc = 10'd45;
    else if (floor_hit && COLLIDE_EN == 0) yc = 10'd505;
    else                                   yc = ys[9:0];
    x1m = PipeX1 - PSPD;
    x2m = PipeX2 - PSPD;
    p1x = PipeX1;
    p1y = PipeY1;
    p2x = PipeX2;
    p2y = PipeY2;
    if (PipeX1 != 10'd0) begin
      if (x1m <= X_LO) begin
        p1x = SPAWN;
        p1y = gap_y;
      end else p1x = x1m;
    end
    if (PipeX2 != 10'd0) begin
      if (x2m <= X_LO) begin
        p2x = SPAWN;
        p2y = gap_y;
      end else p2x = x2m;
    end else if (p1x == X_P2) begin
      p2x = SPAWN;
      p2y = gap_y;
    end
    ssum = {1'b0, score}
         + 17'(PipeX1 > BX && p1x <= BX)
         + 17'(PipeX2 > BX && p2x <= BX);
    crash = (COLLIDE_EN != 0) &&
            (floor_hit || hit(p1x, p1y, yc) || hit(p2x, p2y, yc));
    unique case (st)
      IDLE: if (flap) begin
        st_n    = PLAY;
        vel_n   = FV;
        by_n    = BYF;
        score_n = '0;
        px1_n   = SPAWN;
        py1_n   = gap_y;
        px2_n   = '0;
        py2_n   = Y_RST;
      end
      PLAY: begin
        vel_n   = vp;
        by_n    = yc;
        px1_n   = p1x;
        py1_n   = p1y;
        px2_n   = p2x;
        py2_n   = p2y;
        score_n = ssum[16] ? 16'hFFFF : ssum[15:0];
        if (crash) begin
          st_n   = DEAD;
          dead_n = '0;
        end
      end
      DEAD: begin
        if (dead_cnt >= 16'(DEAD_TICKS) && flap) begin
          st_n  = IDLE;
          vel_n = '0;
          by_n  = BY0;
          px1_n = '0;
          py1_n = Y_RST;
          px2_n = '0;
          py2_n = Y_RST;
        end else if (dead_cnt != 16'hFFFF) begin
          dead_n = dead_cnt + 16'd1;
        end
      end
      default: begin
        st_n   = IDLE;
        vel_n  = '0;
        by_n   = BY0;
        px1_n  = '0;
        py1_n  = Y_RST;
        px2_n  = '0;
        py2_n  = Y_RST;
        dead_n = '0;
      end
    endcase
  end

  // game registers, committed on tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vel      <= '0;
      BirdY    <= BY0;
      PipeX1   <= '0;
      PipeY1   <= Y_RST;
      PipeX2   <= '0;
      PipeY2   <= Y_RST;
      score    <= '0;
      dead_cnt <= '0;
    end else if (upd) begin
      vel      <= vel_n;
      BirdY    <= by_n;
      PipeX1   <= px1_n;
      PipeY1   <= py1_n;
      PipeX2   <= px2_n;
      PipeY2   <= py2_n;
      score    <= score_n;
      dead_cnt <= dead_n;
    end

endmodule

// File: tb/tb_flappy_game_engine.sv
// Bench for flappy_game_engine: scoreboard of expected outputs checked
// after each game tick, three instances (free, collide, shifted bird).
module tb_flappy_game_engine;

  localparam int S_ST = 0, S_BY = 1, S_PX1 = 2, S_PY1 = 3;
  localparam int S_PX2 = 4, S_PY2 = 5, S_SC = 6, S_GO = 7, S_BX = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, reset_n = 1'b0, btn0 = 1'b0, btn1 = 1'b0;
  logic [9:0]  bx [3], by [3], px1 [3], py1 [3], px2 [3], py2 [3];
  logic [15:0] sc [3];
  logic [1:0]  st [3];
  logic        go [3];

  always #5 clk = ~clk;

  flappy_game_engine #(.TICK_DIV(4), .COLLIDE_EN(0)) u_free (
    .clk(clk), .reset_n(reset_n), .button(btn0),
    .BirdX(bx[0]), .BirdY(by[0]), .PipeX1(px1[0]), .PipeY1(py1[0]),
    .PipeX2(px2[0]), .PipeY2(py2[0]), .score(sc[0]), .state(st[0]),
    .game_over(go[0]));

  flappy_game_engine #(.TICK_DIV(4), .COLLIDE_EN(1)) u_col (
    .clk(clk), .reset_n(reset_n), .button(btn1),
    .BirdX(bx[1]), .BirdY(by[1]), .PipeX1(px1[1]), .PipeY1(py1[1]),
    .PipeX2(px2[1]), .PipeY2(py2[1]), .score(sc[1]), .state(st[1]),
    .game_over(go[1]));

  flappy_game_engine #(.TICK_DIV(4), .COLLIDE_EN(1), .BIRD_X(299)) u_col2 (
    .clk(clk), .reset_n(reset_n), .button(btn1),
    .BirdX(bx[2]), .BirdY(by[2]), .PipeX1(px1[2]), .PipeY1(py1[2]),
    .PipeX2(px2[2]), .PipeY2(py2[2]), .score(sc[2]), .state(st[2]),
    .game_over(go[2]));

  typedef struct {
    string       tag;
    int          u;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq [$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  logic [15:0] lfsr_m = SEED, lfsr_tick = '0;
  int          y, v, minx;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [31:0] obs(input int u, input int sel);
    case (sel)
      S_ST:    return 32'(st[u]);
      S_BY:    return 32'(by[u]);
      S_PX1:   return 32'(px1[u]);
      S_PY1:   return 32'(py1[u]);
      S_PX2:   return 32'(px2[u]);
      S_PY2:   return 32'(py2[u]);
      S_SC:    return 32'(sc[u]);
      S_GO:    return 32'(go[u]);
      S_BX:    return 32'(bx[u]);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input int u, input int sel,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.u   = u;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, obs(e.u, e.sel), e.exp);
    end
  endtask

  // one clock; tracks the tick phase and gap generator; ends on negedge
  task automatic step();
    @(posedge clk);
    if (cyc % 4 == 3) lfsr_tick = lfsr_m;
    lfsr_m = lfsr_nx(lfsr_m);
    cyc++;
    @(negedge clk);
  endtask

  // one game tick; a pulse is placed so its edge lands on the tick cycle
  task automatic tick(input logic p0, input logic p1, input logic keep);
    while (cyc % 4 != 1) step();
    btn0 = p0;
    btn1 = p1;
    step();
    if (!keep) begin
      btn0 = 1'b0;
      btn1 = 1'b0;
    end
    step();
    step();
  endtask

  task automatic phys(input bit f, input bit free);
    v = f ? -8 : ((v + 1 > 8) ? 8 : v + 1);
    y = y + v;
    if (y < 45) y = 45;
    if (free && y >= 505) y = 505;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    lfsr_m  = SEED;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit f, hold;
    repeat (3) @(negedge clk);
    want("rst_st", 0, S_ST, 0);
    want("rst_bx", 0, S_BX, 300);
    want("rst_by", 0, S_BY, 275);
    want("rst_px1", 0, S_PX1, 0);
    want("rst_px2", 0, S_PX2, 0);
    want("rst_py1", 0, S_PY1, 200);
    want("rst_py2", 0, S_PY2, 200);
    want("rst_sc", 0, S_SC, 0);
    want("rst_go", 0, S_GO, 0);
    drain();
    release_reset();

    // free-running game: physics, flaps, pipes and score
    want("start_st", 0, S_ST, 1);
    want("start_by", 0, S_BY, 267);
    want("start_px1", 0, S_PX1, 834);
    want("start_px2", 0, S_PX2, 0);
    want("start_sc", 0, S_SC, 0);
    tick(1'b1, 1'b0, 1'b0);
    want("start_py1", 0, S_PY1, 32'(75 + lfsr_tick[7:0]));
    drain();
    y = 267;
    v = -8;
    minx = 1023;
    for (int k = 1; k <= 452; k++) begin
      f    = (k == 80) || (k == 100);
      hold = (k >= 100) && (k <= 104);
      phys(f, 1'b1);
      want($sformatf("by_k%0d", k), 0, S_BY, 32'(y));
      if (k == 60) want("floor_st", 0, S_ST, 1);
      if (k == 185) begin
        want("p185_px1", 0, S_PX1, 464);
        want("p185_px2", 0, S_PX2, 834);
      end
      if (k == 267) begin
        want("p267_px1", 0, S_PX1, 300);
        want("p267_sc", 0, S_SC, 1);
      end
      if (k == 370) want("p370_px1", 0, S_PX1, 834);
      if (k == 452) want("p452_sc", 0, S_SC, 2);
      tick(f || hold, 1'b0, hold);
      if (k == 185) want("p185_py2", 0, S_PY2, 32'(75 + lfsr_tick[7:0]));
      if (k == 370) begin
        want("p370_py1", 0, S_PY1, 32'(75 + lfsr_tick[7:0]));
        check("p370_rng", 32'(py1[0] >= 75 && py1[0] <= 330), 1);
      end
      if (px1[0] != 0 && int'(px1[0]) < minx) minx = int'(px1[0]);
      if (px2[0] != 0 && int'(px2[0]) < minx) minx = int'(px2[0]);
      drain();
    end
    check("pipe_min_x", 32'(minx), 96);

    // asynchronous reset in the middle of play
    reset_n = 1'b0;
    #1;
    want("mid_st", 0, S_ST, 0);
    want("mid_by", 0, S_BY, 275);
    want("mid_px1", 0, S_PX1, 0);
    want("mid_px2", 0, S_PX2, 0);
    want("mid_sc", 0, S_SC, 0);
    want("mid_go", 0, S_GO, 0);
    drain();
    @(negedge clk);
    release_reset();

    // collide instances: floor death
    want("c_start_st", 1, S_ST, 1);
    want("c_start_by", 1, S_BY, 267);
    want("c2_start_st", 2, S_ST, 1);
    tick(1'b0, 1'b1, 1'b0);
    want("c_start_py1", 1, S_PY1, 32'(75 + lfsr_tick[7:0]));
    drain();
    y = 267;
    v = -8;
    for (int k = 1; k <= 45; k++) begin
      phys(1'b0, 1'b0);
      want($sformatf("c_by_k%0d", k), 1, S_BY, 32'(y));
      if (k == 44) want("c_alive44", 1, S_ST, 1);
      if (k == 45) begin
        want("c_floor_st", 1, S_ST, 2);
        want("c_floor_go", 1, S_GO, 1);
        want("c2_floor_st", 2, S_ST, 2);
      end
      tick(1'b0, 1'b0, 1'b0);
      drain();
    end

    // dead hold-off, then restart to idle
    for (int d = 1; d <= 71; d++) begin
      f = (d == 10) || (d == 71);
      if (d == 5) begin
        want("frz_by", 1, S_BY, 507);
        want("frz_px1", 1, S_PX1, 744);
        want("frz_st", 1, S_ST, 2);
        want("frz_sc", 1, S_SC, 0);
      end
      if (d == 10) want("early_btn_st", 1, S_ST, 2);
      if (d == 70) want("wait_st", 1, S_ST, 2);
      if (d == 71) begin
        want("rs_st", 1, S_ST, 0);
        want("rs_go", 1, S_GO, 0);
        want("rs_by", 1, S_BY, 275);
        want("rs_px1", 1, S_PX1, 0);
        want("rs_py1", 1, S_PY1, 200);
        want("rs_sc", 1, S_SC, 0);
        want("rs2_st", 2, S_ST, 0);
      end
      tick(1'b0, f, 1'b0);
      drain();
    end

    // flap every tick: bird pinned at ceiling, pipe edge collision
    for (int k = 0; k <= 238; k++) begin
      if (k == 0) begin
        y = 267;
        v = -8;
      end else begin
        phys(1'b1, 1'b0);
      end
      if (k <= 237) want($sformatf("cc_by_k%0d", k), 1, S_BY, 32'(y));
      if (k == 0) want("cc_start_st", 1, S_ST, 1);
      if (k == 236) begin
        want("dx62_st", 1, S_ST, 1);
        want("dx62_px1", 1, S_PX1, 362);
      end
      if (k == 237) begin
        want("dx60_st", 1, S_ST, 2);
        want("dx60_go", 1, S_GO, 1);
        want("dx60_px1", 1, S_PX1, 360);
        want("dx61_st", 2, S_ST, 1);
        want("dx61_by", 2, S_BY, 45);
      end
      if (k == 238) begin
        want("dx60_frz", 1, S_PX1, 360);
        want("dx59_st", 2, S_ST, 2);
      end
      tick(1'b0, 1'b1, 1'b0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flappy_game_engine.md
Name: flappy_game_engine

Overview:
- Game-state producer for the pixel painter: generates BirdX/BirdY, PipeX1/PipeY1, PipeX2/PipeY2 and score, all consumed by the painter's rgb logic.
- Runs bird physics (gravity, flap), pipe scrolling and respawn, pseudo-random gap heights, collision and scoring.
- Controlled by an IDLE/PLAY/DEAD state machine and advanced by an internal frame tick.

Parameters:
- TICK_DIV, 1666667: clk cycles per game tick (~60 Hz at 100 MHz).
- BIRD_X, 300: fixed bird column.
- BIRD_Y0, 275: bird row in IDLE.
- GRAV, 1: velocity increment per tick.
- FLAP_VEL, -8: signed velocity loaded on a flap.
- VMAX, 8: maximum downward velocity.
- PIPE_SPEED, 2: pipe X decrement per tick.
- GAP, 100: gap height; must match the painter.
- DEAD_TICKS, 60: minimum ticks spent in DEAD.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- COLLIDE_EN, 1: 0 disables all death (bench aid).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- button  in  1  raw flap button, asynchronous to clk.
- BirdX  out  10  bird centre X.
- BirdY  out  10  bird centre Y.
- PipeX1  out  10  pipe 1 centre X; 0 = parked/invisible.
- PipeY1  out  10  pipe 1 gap top.
- PipeX2  out  10  pipe 2 centre X; 0 = parked/invisible.
- PipeY2  out  10  pipe 2 gap top.
- score  out  16  pipes passed, binary, saturating.
- state  out  2  00 IDLE, 01 PLAY, 10 DEAD.
- game_over  out  1  high in DEAD.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, BirdX=BIRD_X, BirdY=BIRD_Y0, vel=0.
  - PipeX1=PipeX2=0, PipeY1=PipeY2=200, score=0, game_over=0.
  - Tick counter=0, LFSR=LFSR_SEED, flap_req=0, dead_cnt=0.
  - Reset mid-game returns to these values immediately.
- Button input:
  - 2-FF synchronizer, then rising-edge detect.
  - An edge sets sticky flap_req. An edge in the same cycle as a tick counts for that tick.
  - flap_req is cleared at every tick.
  - At most one flap per tick.
- Tick:
  - Counter runs 0..TICK_DIV-1; tick is a 1-cycle pulse at TICK_DIV-1, then the counter wraps to 0.
  - All game registers update only on tick.
  - Outputs are registered and change the cycle after the tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clk in all states, so player timing randomizes gaps.
- Gap height: new PipeY = 75 + LFSR[7:0], range 75..330, so the gap bottom is at most 430.
- IDLE:
  - Outputs hold their reset values; score holds the last game's score.
  - On a tick with flap_req: go to PLAY, vel=FLAP_VEL, BirdY=BIRD_Y0+FLAP_VEL, score=0, PipeX1=834, PipeY1 from LFSR, pipe 2 parked.
- PLAY, velocity: vel = flap_req ? FLAP_VEL : min(vel+GRAV, VMAX). vel is 6-bit signed.
- PLAY, bird position:
  - BirdY += vel, using signed arithmetic on 11 bits.
  - Clamp to a minimum of 45 (ceiling; no death at the ceiling).
  - If the result is >= 505: floor hit. Go to DEAD (COLLIDE_EN=1) or clamp to 505 (COLLIDE_EN=0).
- PLAY, pipe movement (each active pipe, X != 0):
  - If X - PIPE_SPEED <= 94: respawn at X=834 with a new PipeY from the LFSR.
  - Otherwise X -= PIPE_SPEED.
- PLAY, pipe 2 activation: pipe 2 activates at X=834, new PipeY, on the tick where pipe 1's new X equals 464. This gives equal 370-pixel spacing; afterwards both pipes respawn independently.
- PLAY, scoring:
  - +1 for each pipe whose X goes from >BIRD_X to <=BIRD_X in this tick.
  - Two pipes in one tick give +2.
  - Saturates at 16'hFFFF.
- PLAY, collision (COLLIDE_EN=1, evaluated on the updated values):
  - Condition, for any active pipe: |BirdX-PipeX| <= 60 AND (BirdY-10 <= PipeY OR BirdY+10 >= PipeY+GAP).
  - On collision: go to DEAD. The update for that tick is still committed.
- DEAD:
  - All positions and score are frozen; game_over=1.
  - dead_cnt counts ticks. flap_req is ignored until dead_cnt >= DEAD_TICKS.
  - The first tick with flap_req after that goes to IDLE: reset-value positions, vel=0, score kept, game_over=0.
- Parked pipe (X=0): the painter's unsigned X-50 wraps to 974, so the pipe is never drawn. Parked pipes are excluded from collision and score.
- Encoding 11 is unreachable; it recovers to IDLE on the next clk.

Test Plan:
All scenarios use TICK_DIV=4.
- Reset: assert reset_n=0 mid-PLAY -> same cycle: state=00, BirdY=275, PipeX1=PipeX2=0, score=0, game_over=0; LFSR=ACE1 after release.
- Start and flap: 1-cycle button pulse in IDLE -> after next tick: state=01, BirdY=267, PipeX1=834, PipeX2=0, score=0. A second pulse landing on a tick cycle is honoured.
- Gravity (no presses, COLLIDE_EN=0):
  - BirdY over successive ticks: 260, 254, 249, 245, 242, 240, 239, 239, 240, ...
  - vel saturates at 8.
  - BirdY clamps at 505 with state staying 01.
  - Holding the button gives only one flap per tick.
- Pipes and score (COLLIDE_EN=0):
  - Tick 185 after start: PipeX1=464, PipeX2=834.
  - Tick 267: PipeX1=300, score=1.
  - Tick 370: PipeX1=834 with a new PipeY in 75..330.
  - Tick 452: score=2.
  - No X value ever falls below 96.
- Floor death (COLLIDE_EN=1, no presses): state=10 and game_over=1 on the first tick where BirdY >= 505; positions are then frozen.
- Restart and collision:
  - In DEAD, button before 60 ticks -> ignored; button after 60 ticks -> IDLE, score retained.
  - Force a misaligned gap with the bird at the pipe edge (|dx|=60): DEAD. With |dx|=61: no death.
